// File: rtl/mem_stage_waitstate.sv
// ---------------------------------------------------------------------------
// mem_stage_waitstate
//
// Pipeline memory stage with an internal word-addressed data memory that sits
// behind a wait-state sequencer. Each load or store stalls the pipeline for
// WAIT_CYCLES cycles and completes on the following cycle. Control and ALU
// fields pass through combinationally. Load data appears in the completing
// cycle and is then held in rdata_q.
//
// Optional feature (macro MEM_STAGE_BOUNDS_CHECK_EN):
//   defined   - accesses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) raise
//               addr_err for the whole access, writes are dropped and reads
//               return 0.
//   undefined - addr_err is tied 0 and addresses alias modulo DEPTH words.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   wb_en_in          write-back enable from EXE/MEM
//   mem_r_en_in       load request
//   mem_w_en_in       store request (wins over load when both are set)
//   alu_res_in        byte address / ALU result
//   val_rm_in         store data
//   dest_in           destination register index
//   wb_en_out, mem_r_en_out, alu_res_out, dest_out
//                     combinational copies of the matching inputs
//   data_memory_out   load data
//   busy              freeze request to upstream stages / pipeline registers
//   addr_err          access outside the memory window (bounds-check build)
//   state_dbg         FSM state, 0 = IDLE, 1 = BUSY
//
// Handshake: an access is requested by holding mem_r_en_in or mem_w_en_in
// together with the address and data. While busy=1 the requester keeps every
// input stable; the access completes in the first cycle where the request is
// present and busy=0, and a new request may be presented right after that
// completing edge without an idle cycle.
// ---------------------------------------------------------------------------
module mem_stage_waitstate #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int DEST_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] val_rm_in,
   input  logic [DEST_W-1:0] dest_in,
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic [DATA_W-1:0] alu_res_out,
   output logic [DEST_W-1:0] dest_out,
   output logic [DATA_W-1:0] data_memory_out,
   output logic              busy,
   output logic              addr_err,
   output logic              state_dbg
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [DATA_W-1:0] BASE = DATA_W'(BASE_ADDR);
   localparam logic [DATA_W:0]   SPAN = (DATA_W + 1)'(4 * DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              req;
   logic              rd_op;
   logic              wr_op;
   logic              complete;
   logic [DATA_W-1:0] offset;
   logic [IDX_W-1:0]  idx;
   logic              in_window;
   logic              acc_ok;
   logic [DATA_W-1:0] rd_word;
   logic              unused_bits;

   // Pass-through fields
   assign wb_en_out    = wb_en_in;
   assign mem_r_en_out = mem_r_en_in;
   assign alu_res_out  = alu_res_in;
   assign dest_out     = dest_in;

   // A store with the load enable also set is treated as a pure store.
   assign req   = mem_r_en_in | mem_w_en_in;
   assign wr_op = mem_w_en_in;
   assign rd_op = mem_r_en_in & ~mem_w_en_in;

   // Offset from the window base; the wrap below BASE is intentional so that
   // the modulo index matches the aliasing behaviour of the default build.
   assign offset    = alu_res_in - BASE;
   assign idx       = offset[IDX_W+1:2];
   assign in_window = (alu_res_in >= BASE) && ({1'b0, offset} < SPAN);

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
   assign acc_ok      = in_window;
   assign addr_err    = req & ~in_window;
   assign unused_bits = ^{offset[DATA_W-1:IDX_W+2], offset[1:0]};
`else
   assign acc_ok      = 1'b1;
   assign addr_err    = 1'b0;
   assign unused_bits = ^{offset[DATA_W-1:IDX_W+2], offset[1:0], in_window};
`endif

   // busy depends only on state, cnt and req. It is also masked by rst so
   // that an aborted access releases the pipeline as soon as reset rises,
   // even while the requester still holds its enables.
   assign busy = ~rst &
                 (((state == IDLE) && req && (WAIT_CYCLES > 0)) ||
                  ((state == BUSY) && (cnt != '0)));

   assign complete = ~rst & req &
                     (((state == IDLE) && (WAIT_CYCLES == 0)) ||
                      ((state == BUSY) && (cnt == '0)));

   assign rd_word   = acc_ok ? mem[idx] : '0;
   assign state_dbg = (state == BUSY);

   always_comb begin
      data_memory_out = rdata_q;
      if (complete && rd_op) begin
         data_memory_out = rd_word;
      end
   end

   // Sequencer: IDLE -> BUSY loads cnt with WAIT_CYCLES-1, BUSY counts down
   // and the cycle with cnt==0 is the completing cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req && (WAIT_CYCLES > 0)) begin
                  state <= BUSY;
                  cnt   <= CNT_W'(WAIT_CYCLES - 1);
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Memory array and held read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (complete && wr_op && acc_ok) begin
            mem[idx] <= val_rm_in;
         end
         if (complete && rd_op) begin
            rdata_q <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_waitstate.sv
// ---------------------------------------------------------------------------
// Bench for mem_stage_waitstate. The reference model is a plain word array
// plus the last load value; every access is expected to take exactly
// WAIT_CYCLES stalled cycles followed by one completing cycle.
// ---------------------------------------------------------------------------
module tb_mem_stage_waitstate;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int BASE   = 1024;
  localparam int WAITC  = 2;
  localparam int DEST_W = 4;

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [DATA_W-1:0] alu_res_in, val_rm_in;
  logic [DEST_W-1:0] dest_in;
  logic              wb_en_out, mem_r_en_out;
  logic [DATA_W-1:0] alu_res_out, data_memory_out;
  logic [DEST_W-1:0] dest_out;
  logic              busy, addr_err, state_dbg;

  mem_stage_waitstate #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .WAIT_CYCLES(WAITC), .DEST_W(DEST_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .dest_out(dest_out),
    .data_memory_out(data_memory_out), .busy(busy),
    .addr_err(addr_err), .state_dbg(state_dbg)
  );

  // scoreboard state
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] model_rdata;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [DATA_W-1:0] addr);
    logic [DATA_W-1:0] off;
    off = addr - DATA_W'(BASE);
    return int'((off >> 2) % DEPTH);
  endfunction

  function automatic bit in_win(input logic [DATA_W-1:0] addr);
    return (addr >= DATA_W'(BASE)) && (addr < DATA_W'(BASE + 4 * DEPTH));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rdata = '0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) check(tag, dut.mem[i], model_mem[i]);
  endtask

  // driver: one non-memory cycle
  task automatic idle_cycle();
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    wb_en_in    = 1'($urandom_range(0, 1));
    alu_res_in  = $urandom;
    val_rm_in   = $urandom;
    dest_in     = DEST_W'($urandom_range(0, 15));
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_addr_err", addr_err, 1'b0);
    check("idle_hold", data_memory_out, model_rdata);
    check("idle_wb", wb_en_out, wb_en_in);
    check("idle_alu", alu_res_out, alu_res_in);
    check("idle_dest", dest_out, dest_in);
    check("idle_rd_en", mem_r_en_out, mem_r_en_in);
    @(posedge clk); #1;
  endtask

  // driver: one complete memory access held for its whole occupancy
  task automatic do_access(input logic r, input logic w,
                           input logic [DATA_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input string tag);
    int ix;
    bit ok;
    bit rd_op;
    logic [DATA_W-1:0] exp_rd;
    ix    = idx_of(addr);
    ok    = BCHK ? in_win(addr) : 1'b1;
    rd_op = r & ~w;
    mem_r_en_in = r;
    mem_w_en_in = w;
    alu_res_in  = addr;
    val_rm_in   = data;
    wb_en_in    = 1'($urandom_range(0, 1));
    dest_in     = DEST_W'($urandom_range(0, 15));
    exp_rd = rd_op ? (ok ? model_mem[ix] : '0) : model_rdata;
    for (int c = 0; c <= WAITC; c++) begin
      @(negedge clk);
      check({tag, "_busy"}, busy, (c < WAITC) ? 1'b1 : 1'b0);
      check({tag, "_addr_err"}, addr_err, (BCHK && !ok) ? 1'b1 : 1'b0);
      if (c == 0) check({tag, "_alu"}, alu_res_out, addr);
      if (c == WAITC) check({tag, "_data"}, data_memory_out, exp_rd);
      else check({tag, "_prehold"}, data_memory_out, model_rdata);
      @(posedge clk); #1;
    end
    if (w && ok) model_mem[ix] = data;
    if (rd_op) model_rdata = exp_rd;
  endtask

  initial begin
    int kind, op;
    logic [DATA_W-1:0] a;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_res_in = 0; val_rm_in = 0; dest_in = 0;
    model_reset();

    // reset asserted off the clock edge
    #7 rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_data", data_memory_out, '0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_state", state_dbg, 1'b0);
    check_mem("rst_mem");
    #6 rst = 1'b0;
    @(posedge clk); #1;

    // directed write then read
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, "wr1028");
    check("mem1", dut.mem[1], 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'd1028, '0, "rd1028");
    idle_cycle();

    // back-to-back write/read, then write-only with both enables
    do_access(1'b0, 1'b1, 32'd1032, 32'h11, "wr1032");
    do_access(1'b1, 1'b0, 32'd1032, '0, "rd1032");
    do_access(1'b1, 1'b1, 32'd1040, 32'h99, "rw1040");
    idle_cycle();

    // window boundary / aliasing
    do_access(1'b0, 1'b1, 32'd1280, 32'h55, "wr1280");
    do_access(1'b1, 1'b0, 32'd1024, '0, "rd1024");
    do_access(1'b1, 1'b0, 32'd1280, '0, "rd1280");
    do_access(1'b1, 1'b0, 32'd1276, '0, "rd1276");
    idle_cycle();

    // reset during the second cycle of a write
    mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
    alu_res_in = 32'd1036; val_rm_in = 32'h77;
    @(negedge clk);
    check("abort_busy0", busy, 1'b1);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_state", state_dbg, 1'b0);
    model_reset();
    mem_w_en_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("abort_mem3", dut.mem[3], '0);
    check("abort_idle", state_dbg, 1'b0);
    do_access(1'b1, 1'b0, 32'd1036, '0, "rd1036");

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        idle_cycle();
      end else begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 2))
            0: a = 32'd1280 + 4 * $urandom_range(0, 63);
            1: a = 32'd1024 - 4 * $urandom_range(1, 40);
            default: a = $urandom;
          endcase
        end else begin
          a = 32'd1024 + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3);
        end
        op = $urandom_range(0, 4);
        do_access(op >= 2, op <= 1 || op == 4, a, $urandom, "rnd");
      end
    end
    idle_cycle();
    check_mem("final_mem");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
